// File: rtl/cla_mp_pkg.sv
// Shared types for the multi-precision add/subtract sequencer.
// Holds the FSM state enum and the word-index width helper.
package cla_mp_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Width of the word index; never zero, even when WORDS is 1.
    function automatic int idx_w(input int words);
        if (words <= 2) return 1;
        return $clog2(words);
    endfunction

endpackage

// File: rtl/cla_word_add.sv
// Combinational Ancho-bit carry-lookahead word adder.
// Ports: a, b, ci -> s, co (carry out), c_msb_in (carry into bit Ancho-1).
module cla_word_add #(
    parameter int Ancho = 8
) (
    input  logic [Ancho-1:0] a,
    input  logic [Ancho-1:0] b,
    input  logic             ci,
    output logic [Ancho-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [Ancho-1:0] w_g;
    logic [Ancho-1:0] w_p;
    logic [Ancho:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Each carry is a flat sum of products of G/P terms, so no
    // carry depends on another carry.
    always_comb begin
        logic w_t;
        logic w_acc;
        w_c    = '0;
        w_c[0] = ci;
        for (int i = 0; i < Ancho; i++) begin
            w_t = ci;
            for (int j = 0; j <= i; j++) begin
                w_t = w_t & w_p[j];
            end
            w_acc = w_t;
            for (int j = 0; j <= i; j++) begin
                w_t = w_g[j];
                for (int k = j + 1; k <= i; k++) begin
                    w_t = w_t & w_p[k];
                end
                w_acc = w_acc | w_t;
            end
            w_c[i+1] = w_acc;
        end
    end

    assign s        = w_p ^ w_c[Ancho-1:0];
    assign co       = w_c[Ancho];
    assign c_msb_in = w_c[Ancho-1];

endmodule

// File: rtl/cla_mp_seq.sv
// Multi-precision add/subtract sequencer: one word per cycle, LSW first.
// Ports: start_* command handshake, res_* result handshake, flush, busy.
module cla_mp_seq
    import cla_mp_pkg::*;
#(
    parameter int Ancho = 8,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [WORDS*Ancho-1:0] a_wide,
    input  logic [WORDS*Ancho-1:0] b_wide,
    input  logic                   cin,
    input  logic                   sub,
    input  logic                   flush,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WORDS*Ancho-1:0] sum_wide,
    output logic                   cout,
    output logic                   overflow,
    output logic                   busy
);

    localparam int N  = WORDS * Ancho;
    localparam int IW = idx_w(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    state_t          r_state;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic            r_sub;
    logic [IW-1:0]   r_idx;
    logic            r_carry;
    logic [N-1:0]    r_sum;
    logic            r_cout;
    logic            r_ovf;
    logic            r_res_valid;
    logic            r_busy;

    logic [Ancho-1:0] w_a_word;
    logic [Ancho-1:0] w_b_word;
    logic [Ancho-1:0] w_s;
    logic             w_co;
    logic             w_cmsb;

    always_comb begin
        w_a_word = '0;
        w_b_word = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (r_idx == IW'(i)) begin
                w_a_word = r_a[i*Ancho +: Ancho];
                w_b_word = r_b[i*Ancho +: Ancho];
            end
        end
    end

    cla_word_add #(
        .Ancho (Ancho)
    ) u_add (
        .a        (w_a_word),
        .b        (r_sub ? ~w_b_word : w_b_word),
        .ci       (r_carry),
        .s        (w_s),
        .co       (w_co),
        .c_msb_in (w_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sub       <= 1'b0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    // flush in IDLE only blocks the command
                    if (start_valid && !flush) begin
                        r_a     <= a_wide;
                        r_b     <= b_wide;
                        r_sub   <= sub;
                        r_idx   <= '0;
                        // subtract is A + ~B + 1
                        r_carry <= sub | cin;
                        r_sum   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        for (int i = 0; i < WORDS; i++) begin
                            if (r_idx == IW'(i)) begin
                                r_sum[i*Ancho +: Ancho] <= w_s;
                            end
                        end
                        r_carry <= w_co;
                        r_idx   <= r_idx + 1'b1;
                        if (r_idx == LAST) begin
                            r_cout      <= w_co;
                            r_ovf       <= w_co ^ w_cmsb;
                            r_res_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (flush) begin
                        r_sum       <= '0;
                        r_cout      <= 1'b0;
                        r_ovf       <= 1'b0;
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign start_ready = (r_state == S_IDLE);
    assign res_valid   = r_res_valid;
    assign busy        = r_busy;
    assign sum_wide    = r_sum;
    assign cout        = r_cout;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_cla_mp_seq.sv
// Self-checking bench for cla_mp_seq (Ancho=8, WORDS=4).
// Compares against a full-width arithmetic reference model.
module tb_cla_mp_seq;

    localparam int ANCHO = 8;
    localparam int WORDS = 4;
    localparam int N     = ANCHO * WORDS;

    logic         clk;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [N-1:0] a_wide;
    logic [N-1:0] b_wide;
    logic         cin;
    logic         sub;
    logic         flush;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] sum_wide;
    logic         cout;
    logic         overflow;
    logic         busy;

    int vecs = 0;
    int errs = 0;

    cla_mp_seq #(
        .Ancho (ANCHO),
        .WORDS (WORDS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_wide      (a_wide),
        .b_wide      (b_wide),
        .cin         (cin),
        .sub         (sub),
        .flush       (flush),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum_wide    (sum_wide),
        .cout        (cout),
        .overflow    (overflow),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain (N+1)-bit arithmetic; returns {ovf, cout, sum}.
    function automatic logic [N+1:0] model(
        input logic [N-1:0] a,
        input logic [N-1:0] b,
        input logic         c,
        input logic         s
    );
        logic [N:0]   r;
        logic [N-1:0] bb;
        logic         ci;
        logic         ov;
        bb = s ? ~b : b;
        ci = s ? 1'b1 : c;
        r  = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, ci};
        if (s)
            ov = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
        else
            ov = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
        return {ov, r[N], r[N-1:0]};
    endfunction

    // Issue one command, wait (bounded) for res_valid; lat = edges taken.
    task automatic run_op(
        input  logic [N-1:0] a,
        input  logic [N-1:0] b,
        input  logic         c,
        input  logic         s,
        output int           lat
    );
        @(negedge clk);
        a_wide      = a;
        b_wide      = b;
        cin         = c;
        sub         = s;
        start_valid = 1'b1;
        res_ready   = 1'b0;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        a_wide      = $urandom;
        b_wide      = $urandom;
        cin         = 1'($urandom);
        sub         = 1'($urandom);
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic accept;
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        start_valid = 1'b0;
        res_ready   = 1'b0;
        flush       = 1'b0;
        a_wide      = '0;
        b_wide      = '0;
        cin         = 1'b0;
        sub         = 1'b0;
        repeat (3) @(negedge clk);
        vecs++;
        if ({res_valid, busy, start_ready, cout, overflow} !== 5'b00100) begin
            errs++;
            $display("FAIL reset_ctrl: got %b expected 00100",
                     {res_valid, busy, start_ready, cout, overflow});
        end
        vecs++;
        if (sum_wide !== '0) begin
            errs++;
            $display("FAIL reset_sum: got %h expected 0", sum_wide);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [N-1:0] ta [6];
        logic [N-1:0] tb [6];
        logic         tc [6];
        logic         ts [6];
        logic [N-1:0] es [6];
        logic         ec [6];
        logic         eo [6];
        int           lat;
        ta = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
               32'h0000_0000, 32'h8000_0000, 32'h1234_5678};
        tb = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0001,
               32'h0000_0001, 32'h0000_0001, 32'h1234_5678};
        tc = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        ts = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        es = '{32'h0000_0100, 32'h0000_0000, 32'h8000_0000,
               32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000};
        ec = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        eo = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], tb[i], tc[i], ts[i], lat);
            vecs++;
            if (lat !== WORDS) begin
                errs++;
                $display("FAIL dir%0d_latency: got %0d expected %0d",
                         i, lat, WORDS);
            end
            vecs++;
            if ({overflow, cout, sum_wide} !== {eo[i], ec[i], es[i]}) begin
                errs++;
                $display("FAIL dir%0d_result: got ov=%b co=%b s=%h expected ov=%b co=%b s=%h",
                         i, overflow, cout, sum_wide, eo[i], ec[i], es[i]);
            end
            accept();
            vecs++;
            if ({res_valid, start_ready, busy} !== 3'b010) begin
                errs++;
                $display("FAIL dir%0d_accept: got %b expected 010",
                         i, {res_valid, start_ready, busy});
            end
        end
    endtask

    task automatic test_random;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         c;
        logic         s;
        logic [N+1:0] exp;
        int           lat;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            c = 1'($urandom);
            s = 1'($urandom);
            if (i % 8 == 0) b = a;
            exp = model(a, b, c, s);
            run_op(a, b, c, s, lat);
            vecs++;
            if (lat !== WORDS || {overflow, cout, sum_wide} !== exp) begin
                errs++;
                $display("FAIL rnd%0d: got lat=%0d %h expected lat=%0d %h",
                         i, lat, {overflow, cout, sum_wide}, WORDS, exp);
            end
            accept();
        end
    endtask

    task automatic test_backpressure;
        logic [N+1:0] e1;
        logic [N+1:0] e2;
        int           lat;
        e1 = model(32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1, 1'b0);
        e2 = model(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, 1'b1);
        run_op(32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1, 1'b0, lat);
        vecs++;
        if (lat !== WORDS) begin
            errs++;
            $display("FAIL bp_latency: got %0d expected %0d", lat, WORDS);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start_valid = 1'b1;
            a_wide      = 32'h0F0F_0F0F;
            b_wide      = 32'hF0F0_F0F1;
            cin         = 1'b0;
            sub         = 1'b1;
            #1;
            vecs++;
            if ({res_valid, start_ready, busy} !== 3'b101 ||
                {overflow, cout, sum_wide} !== e1) begin
                errs++;
                $display("FAIL bp_hold%0d: got ctl=%b r=%h expected ctl=101 r=%h",
                         k, {res_valid, start_ready, busy},
                         {overflow, cout, sum_wide}, e1);
            end
        end
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        vecs++;
        if ({res_valid, start_ready, busy} !== 3'b010 ||
            {overflow, cout, sum_wide} !== e1) begin
            errs++;
            $display("FAIL bp_release: got ctl=%b r=%h expected ctl=010 r=%h",
                     {res_valid, start_ready, busy},
                     {overflow, cout, sum_wide}, e1);
        end
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        vecs++;
        if ({start_ready, busy} !== 2'b01) begin
            errs++;
            $display("FAIL bp_second_accept: got %b expected 01",
                     {start_ready, busy});
        end
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        vecs++;
        if (lat !== WORDS || {overflow, cout, sum_wide} !== e2) begin
            errs++;
            $display("FAIL bp_second_result: got lat=%0d %h expected lat=%0d %h",
                     lat, {overflow, cout, sum_wide}, WORDS, e2);
        end
        accept();
    endtask

    task automatic test_flush;
        int   lat;
        logic seen;
        @(negedge clk);
        a_wide      = 32'h1111_1111;
        b_wide      = 32'h2222_2222;
        cin         = 1'b0;
        sub         = 1'b0;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        vecs++;
        if (sum_wide !== 32'h0000_3333) begin
            errs++;
            $display("FAIL flush_partial: got %h expected 00003333", sum_wide);
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        vecs++;
        if ({res_valid, busy, start_ready, cout, overflow} !== 5'b00100 ||
            sum_wide !== '0) begin
            errs++;
            $display("FAIL flush_run: got ctl=%b s=%h expected ctl=00100 s=0",
                     {res_valid, busy, start_ready, cout, overflow}, sum_wide);
        end
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        vecs++;
        if (seen !== 1'b0) begin
            errs++;
            $display("FAIL flush_no_valid: got %b expected 0", seen);
        end
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
        @(negedge clk);
        flush     = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        res_ready = 1'b0;
        vecs++;
        if ({res_valid, busy, start_ready, cout, overflow} !== 5'b00100 ||
            sum_wide !== '0) begin
            errs++;
            $display("FAIL flush_done: got ctl=%b s=%h expected ctl=00100 s=0",
                     {res_valid, busy, start_ready, cout, overflow}, sum_wide);
        end
        @(negedge clk);
        start_valid = 1'b1;
        flush       = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        flush       = 1'b0;
        vecs++;
        if ({start_ready, busy} !== 2'b10) begin
            errs++;
            $display("FAIL flush_idle_block: got %b expected 10",
                     {start_ready, busy});
        end
    endtask

    task automatic test_async_reset;
        int           lat;
        logic [N+1:0] exp;
        @(negedge clk);
        a_wide      = 32'h1234_5678;
        b_wide      = 32'h1111_1111;
        cin         = 1'b0;
        sub         = 1'b0;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({res_valid, busy, start_ready, cout, overflow} !== 5'b00100 ||
            sum_wide !== '0) begin
            errs++;
            $display("FAIL async_reset: got ctl=%b s=%h expected ctl=00100 s=0",
                     {res_valid, busy, start_ready, cout, overflow}, sum_wide);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp = model(32'hCAFE_F00D, 32'h0BAD_BEEF, 1'b0, 1'b1);
        run_op(32'hCAFE_F00D, 32'h0BAD_BEEF, 1'b0, 1'b1, lat);
        vecs++;
        if (lat !== WORDS || {overflow, cout, sum_wide} !== exp) begin
            errs++;
            $display("FAIL after_reset: got lat=%0d %h expected lat=%0d %h",
                     lat, {overflow, cout, sum_wide}, WORDS, exp);
        end
        accept();
    endtask

    task automatic test_back_to_back;
        logic [N+1:0] exp;
        int           tx[$];
        int           nres;
        exp = model(32'h89AB_CDEF, 32'h7654_3210, 1'b1, 1'b0);
        @(negedge clk);
        a_wide      = 32'h89AB_CDEF;
        b_wide      = 32'h7654_3210;
        cin         = 1'b1;
        sub         = 1'b0;
        start_valid = 1'b1;
        res_ready   = 1'b1;
        nres        = 0;
        for (int cyc = 0; cyc < 26; cyc++) begin
            if (start_ready) tx.push_back(cyc);
            if (res_valid) begin
                nres++;
                vecs++;
                if ({overflow, cout, sum_wide} !== exp) begin
                    errs++;
                    $display("FAIL b2b_result: got %h expected %h",
                             {overflow, cout, sum_wide}, exp);
                end
            end
            @(negedge clk);
        end
        start_valid = 1'b0;
        vecs++;
        if (tx.size() !== 5 || nres !== 4) begin
            errs++;
            $display("FAIL b2b_count: got tx=%0d res=%0d expected tx=5 res=4",
                     tx.size(), nres);
        end
        for (int i = 1; i < tx.size(); i++) begin
            vecs++;
            if (tx[i] - tx[i-1] !== WORDS + 2) begin
                errs++;
                $display("FAIL b2b_period%0d: got %0d expected %0d",
                         i, tx[i] - tx[i-1], WORDS + 2);
            end
        end
        repeat (10) @(negedge clk);
        res_ready = 1'b0;
        vecs++;
        if ({start_ready, busy} !== 2'b10) begin
            errs++;
            $display("FAIL b2b_drain: got %b expected 10", {start_ready, busy});
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
